// File: rtl/fsm_sig_monitor_pkg.sv
// Shared types and constants for the output-side FSM signature monitor.
package fsm_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mon_state_t;

   localparam logic [16:0] DEF_POLY     = 17'h04001;
   localparam logic [16:0] DEF_REC_MASK = 17'h00181;

   typedef logic [15:0] cnt16_t;

   // Event counters stick at all-ones instead of wrapping.
   function automatic cnt16_t sat_inc(input cnt16_t c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

endpackage

// File: rtl/fsm_sig_monitor_if.sv
// Control/observation bundle between the monitored FSM side and fsm_sig_monitor.
interface fsm_sig_monitor_if #(
   parameter int WIDTH = 17
);
   import fsm_mon_pkg::*;

   logic             start;
   logic             en;
   logic [WIDTH-1:0] y_vec;
   logic [WIDTH-1:0] exp_sig;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] signature;
   logic             match;
   cnt16_t           zero_count;
   cnt16_t           rec_count;

   modport master (
      output start, en, y_vec, exp_sig,
      input  busy, done, signature, match, zero_count, rec_count
   );

   modport slave (
      input  start, en, y_vec, exp_sig,
      output busy, done, signature, match, zero_count, rec_count
   );

endinterface

// File: rtl/fsm_sig_monitor_misr_step.sv
// One MISR fold: shift left, apply feedback on the outgoing MSB, xor in the sample.
module misr_step #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] sig,
   input  logic [WIDTH-1:0] y_vec,
   input  logic [WIDTH-1:0] poly,
   output logic [WIDTH-1:0] sig_n
);

   assign sig_n = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? poly : '0) ^ y_vec;

endmodule

// File: rtl/fsm_sig_monitor.sv
// Folds a window of FSM output vectors into a MISR signature, counts all-zero and
// record-pattern samples, and compares the final signature against a golden value.
module fsm_sig_monitor
   import fsm_mon_pkg::*;
#(
   parameter int               WIDTH    = 17,
   parameter int               WINDOW   = 256,
   parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] REC_MASK = WIDTH'(DEF_REC_MASK)
) (
   input logic              clk,
   input logic              rst,
   fsm_sig_monitor_if.slave bus
);

   localparam int            CW       = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

   mon_state_t       state, state_n;
   logic [WIDTH-1:0] sig, sig_n, sig_q;
   logic [CW-1:0]    cnt;
   cnt16_t           zc, rc, zc_n, rc_n, zero_q, rec_q;
   logic             match_q;
   logic             fold, last;

   misr_step #(.WIDTH(WIDTH)) u_step (
      .sig   (sig),
      .y_vec (bus.y_vec),
      .poly  (POLY),
      .sig_n (sig_n)
   );

   assign fold = (state == RUN) && bus.en;
   assign last = fold && (cnt == LAST_IDX);
   assign zc_n = (bus.y_vec == '0) ? sat_inc(zc) : zc;
   assign rc_n = ((bus.y_vec & REC_MASK) == REC_MASK) ? sat_inc(rc) : rc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = RUN;
         RUN:     if (last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig     <= '0;
         cnt     <= '0;
         zc      <= '0;
         rc      <= '0;
         sig_q   <= '0;
         zero_q  <= '0;
         rec_q   <= '0;
         match_q <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         sig <= '0;
         cnt <= '0;
         zc  <= '0;
         rc  <= '0;
      end else if (fold) begin
         sig <= sig_n;
         cnt <= cnt + 1'b1;
         zc  <= zc_n;
         rc  <= rc_n;
         // Result registers take the post-fold values so the last sample counts.
         if (last) begin
            sig_q   <= sig_n;
            zero_q  <= zc_n;
            rec_q   <= rc_n;
            match_q <= (sig_n == bus.exp_sig);
         end
      end
   end

   assign bus.busy       = (state == RUN);
   assign bus.done       = (state == DONE);
   assign bus.signature  = sig_q;
   assign bus.match      = match_q;
   assign bus.zero_count = zero_q;
   assign bus.rec_count  = rec_q;

endmodule

// File: tb/tb_fsm_sig_monitor.sv
// Randomized self-checking bench: four monitor instances (windows 4, 2, 3, 65535)
// checked against a polynomial-arithmetic reference model.
module tb_fsm_sig_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]       start_d = '0, en_d = '0;
   logic [3:0][16:0] y_d = '0, exp_d = '0;
   logic [3:0]       busy_d, done_d, match_d;
   logic [3:0][16:0] sig_d;
   logic [3:0][15:0] zc_d, rc_d;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      fsm_sig_monitor_if #(.WIDTH(17)) bus ();
      assign bus.start   = start_d[gi];
      assign bus.en      = en_d[gi];
      assign bus.y_vec   = y_d[gi];
      assign bus.exp_sig = exp_d[gi];
      assign busy_d[gi]  = bus.busy;
      assign done_d[gi]  = bus.done;
      assign match_d[gi] = bus.match;
      assign sig_d[gi]   = bus.signature;
      assign zc_d[gi]    = bus.zero_count;
      assign rc_d[gi]    = bus.rec_count;
      fsm_sig_monitor #(
         .WIDTH    (17),
         .WINDOW   (gi == 0 ? 4 : gi == 1 ? 2 : gi == 2 ? 3 : 65535),
         .POLY     (17'h04001),
         .REC_MASK (17'h00181)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   int n_vec = 0;
   int n_bad = 0;

   logic [16:0] q_y[$];
   logic [16:0] m_sig;
   int          m_z, m_r;
   int          run_bad;
   logic        o_done_fin, o_busy_fin, o_done_aft, o_busy_aft;
   logic [16:0] o_sig_run;

   // Multiply by x modulo x^17+x^14+1, then add the sample.
   function automatic logic [16:0] ref_fold(input logic [16:0] s, input logic [16:0] y);
      logic [17:0] t;
      t = {s, 1'b0};
      if (t[17]) t = t ^ 18'h24001;
      return t[16:0] ^ y;
   endfunction

   task automatic model();
      m_sig = '0; m_z = 0; m_r = 0;
      foreach (q_y[i]) begin
         m_sig = ref_fold(m_sig, q_y[i]);
         if (q_y[i] == 17'h0) m_z++;
         if ((q_y[i] & 17'h00181) == 17'h00181) m_r++;
      end
      if (m_z > 65535) m_z = 65535;
      if (m_r > 65535) m_r = 65535;
   endtask

   // Drives one window from q_y; entered and left just after a negedge.
   task automatic drive_window(input int d, input int gap_pct, input bit start_mid,
                               input bit start_in_done, input logic [16:0] exp);
      run_bad = 0;
      start_d[d] = 1'b1; exp_d[d] = exp;
      @(negedge clk);
      start_d[d] = 1'b0;
      if (busy_d[d] !== 1'b1 || done_d[d] !== 1'b0) run_bad++;
      for (int i = 0; i < q_y.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin
            en_d[d] = 1'b0; y_d[d] = 17'($urandom);
            @(negedge clk);
            if (busy_d[d] !== 1'b1 || done_d[d] !== 1'b0) run_bad++;
         end
         en_d[d] = 1'b1; y_d[d] = q_y[i];
         if (start_mid && i == 1) start_d[d] = 1'b1;
         @(negedge clk);
         start_d[d] = 1'b0;
         if (i == 0) o_sig_run = sig_d[d];
         if (i != q_y.size() - 1 && (busy_d[d] !== 1'b1 || done_d[d] !== 1'b0)) run_bad++;
      end
      en_d[d] = 1'b0; y_d[d] = 17'($urandom);
      o_done_fin = done_d[d]; o_busy_fin = busy_d[d];
      if (start_in_done) start_d[d] = 1'b1;
      @(negedge clk);
      start_d[d] = 1'b0;
      o_done_aft = done_d[d]; o_busy_aft = busy_d[d];
   endtask

   task automatic test_reset();
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         n_vec++;
         if ({busy_d[d], done_d[d], match_d[d], sig_d[d], zc_d[d], rc_d[d]} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs dut%0d busy=%b done=%b match=%b sig=%h zc=%h rc=%h want all 0",
                     d, busy_d[d], done_d[d], match_d[d], sig_d[d], zc_d[d], rc_d[d]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_zero();
      q_y = {17'h0, 17'h0, 17'h0, 17'h0};
      drive_window(0, 0, 0, 0, 17'h0);
      n_vec++; if (run_bad != 0 || o_done_fin !== 1'b1 || o_busy_fin !== 1'b0 || o_done_aft !== 1'b0) begin
         n_bad++; $display("FAIL zero_timing run_bad=%0d done=%b busy=%b done_next=%b want 0 1 0 0",
                           run_bad, o_done_fin, o_busy_fin, o_done_aft); end
      n_vec++; if (sig_d[0] !== 17'h0 || zc_d[0] !== 16'd4 || rc_d[0] !== 16'd0 || match_d[0] !== 1'b1) begin
         n_bad++; $display("FAIL zero_result sig=%h zc=%0d rc=%0d match=%b want 0 4 0 1",
                           sig_d[0], zc_d[0], rc_d[0], match_d[0]); end
   endtask

   task automatic test_fold_stall();
      // First sample, forced gap, then the second sample.
      start_d[1] = 1'b1; exp_d[1] = 17'h0;
      @(negedge clk); start_d[1] = 1'b0;
      en_d[1] = 1'b1; y_d[1] = 17'h00001;
      @(negedge clk);
      en_d[1] = 1'b0; y_d[1] = 17'h1FFFF;
      repeat (3) @(negedge clk);
      n_vec++; if (busy_d[1] !== 1'b1 || done_d[1] !== 1'b0) begin
         n_bad++; $display("FAIL stall_state busy=%b done=%b want 1 0", busy_d[1], done_d[1]); end
      en_d[1] = 1'b1; y_d[1] = 17'h00000;
      @(negedge clk);
      en_d[1] = 1'b0;
      n_vec++; if (done_d[1] !== 1'b1 || sig_d[1] !== 17'h00002 || zc_d[1] !== 16'd1 || match_d[1] !== 1'b0) begin
         n_bad++; $display("FAIL fold_stall done=%b sig=%h zc=%0d match=%b want 1 00002 1 0",
                           done_d[1], sig_d[1], zc_d[1], match_d[1]); end
      @(negedge clk);
   endtask

   task automatic test_msb_feedback();
      q_y = {17'h10000, 17'h00000};
      drive_window(1, 30, 0, 0, 17'h04001);
      n_vec++; if (o_done_fin !== 1'b1 || sig_d[1] !== 17'h04001 || match_d[1] !== 1'b1) begin
         n_bad++; $display("FAIL msb_feedback done=%b sig=%h match=%b want 1 04001 1",
                           o_done_fin, sig_d[1], match_d[1]); end
      drive_window(1, 0, 0, 0, 17'h04000);
      n_vec++; if (sig_d[1] !== 17'h04001 || match_d[1] !== 1'b0) begin
         n_bad++; $display("FAIL msb_nomatch sig=%h match=%b want 04001 0", sig_d[1], match_d[1]); end
   endtask

   task automatic test_records();
      q_y = {17'h00181, 17'h00183, 17'h00180};
      model();
      drive_window(2, 20, 0, 0, 17'h0);
      n_vec++; if (rc_d[2] !== 16'd2 || zc_d[2] !== 16'd0 || sig_d[2] !== m_sig || o_done_fin !== 1'b1) begin
         n_bad++; $display("FAIL records rc=%0d zc=%0d sig=%h done=%b want 2 0 %h 1",
                           rc_d[2], zc_d[2], sig_d[2], o_done_fin, m_sig); end
   endtask

   task automatic test_random();
      for (int w = 0; w < 24; w++) begin
         int d, len;
         logic [16:0] exp;
         d   = (w % 2 == 0) ? 0 : 2;
         len = (d == 0) ? 4 : 3;
         q_y.delete();
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(3))
               0:       q_y.push_back(17'h0);
               1:       q_y.push_back(17'h00181 | 17'($urandom));
               default: q_y.push_back(17'($urandom));
            endcase
         end
         model();
         exp = $urandom_range(1) ? m_sig : 17'($urandom);
         drive_window(d, 25, 0, 0, exp);
         n_vec++;
         if (run_bad != 0 || o_done_fin !== 1'b1 || o_busy_fin !== 1'b0 || o_done_aft !== 1'b0 ||
             sig_d[d] !== m_sig || zc_d[d] !== 16'(m_z) || rc_d[d] !== 16'(m_r) ||
             match_d[d] !== (m_sig == exp)) begin
            n_bad++;
            $display("FAIL random_w%0d dut%0d sig=%h zc=%0d rc=%0d match=%b done=%b run_bad=%0d want %h %0d %0d %b 1 0",
                     w, d, sig_d[d], zc_d[d], rc_d[d], match_d[d], o_done_fin, run_bad,
                     m_sig, m_z, m_r, m_sig == exp);
         end
      end
   endtask

   task automatic test_reset_abort();
      int seen_done;
      seen_done = 0;
      start_d[0] = 1'b1;
      @(negedge clk); start_d[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         en_d[0] = 1'b1; y_d[0] = 17'h00181;
         @(negedge clk);
      end
      en_d[0] = 1'b0; rst = 1'b1;
      #1;
      n_vec++; if ({busy_d[0], done_d[0], match_d[0], sig_d[0], zc_d[0], rc_d[0]} !== '0) begin
         n_bad++; $display("FAIL abort_outputs busy=%b done=%b match=%b sig=%h zc=%h rc=%h want all 0",
                           busy_d[0], done_d[0], match_d[0], sig_d[0], zc_d[0], rc_d[0]); end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         en_d[0] = 1'b1; y_d[0] = 17'($urandom);
         @(negedge clk);
         if (done_d[0] !== 1'b0 || busy_d[0] !== 1'b0) seen_done++;
      end
      en_d[0] = 1'b0;
      n_vec++; if (seen_done != 0) begin
         n_bad++; $display("FAIL abort_idle bad_cycles=%0d want 0", seen_done); end
      q_y = {17'h00003, 17'h10000, 17'h00181, 17'h00000};
      model();
      drive_window(0, 20, 1, 0, m_sig);
      n_vec++; if (run_bad != 0 || o_done_fin !== 1'b1 || sig_d[0] !== m_sig || zc_d[0] !== 16'(m_z) ||
                   rc_d[0] !== 16'(m_r) || match_d[0] !== 1'b1) begin
         n_bad++; $display("FAIL start_in_run run_bad=%0d done=%b sig=%h zc=%0d rc=%0d match=%b want 0 1 %h %0d %0d 1",
                           run_bad, o_done_fin, sig_d[0], zc_d[0], rc_d[0], match_d[0], m_sig, m_z, m_r); end
   endtask

   task automatic test_back_to_back();
      logic [16:0] prev;
      q_y = {17'h1ABCD, 17'h00181, 17'h0};
      model(); prev = m_sig;
      drive_window(2, 0, 0, 1, 17'h0);
      n_vec++; if (o_done_fin !== 1'b1 || o_busy_aft !== 1'b0 || sig_d[2] !== prev) begin
         n_bad++; $display("FAIL start_in_done done=%b busy_after=%b sig=%h want 1 0 %h",
                           o_done_fin, o_busy_aft, sig_d[2], prev); end
      q_y = {17'h00001, 17'h12345, 17'h00181};
      model();
      drive_window(2, 0, 0, 0, m_sig);
      n_vec++; if (o_sig_run !== prev) begin
         n_bad++; $display("FAIL hold_outputs sig_during_run=%h want %h", o_sig_run, prev); end
      n_vec++; if (run_bad != 0 || o_done_fin !== 1'b1 || sig_d[2] !== m_sig || match_d[2] !== 1'b1 ||
                   rc_d[2] !== 16'(m_r)) begin
         n_bad++; $display("FAIL back_to_back run_bad=%0d done=%b sig=%h match=%b rc=%0d want 0 1 %h 1 %0d",
                           run_bad, o_done_fin, sig_d[2], match_d[2], rc_d[2], m_sig, m_r); end
   endtask

   task automatic test_saturation();
      q_y.delete();
      for (int i = 0; i < 65535; i++) q_y.push_back(17'h0);
      drive_window(3, 0, 0, 0, 17'h0);
      n_vec++; if (o_done_fin !== 1'b1 || zc_d[3] !== 16'hFFFF || rc_d[3] !== 16'd0 || sig_d[3] !== 17'h0) begin
         n_bad++; $display("FAIL saturation done=%b zc=%h rc=%h sig=%h want 1 ffff 0000 00000",
                           o_done_fin, zc_d[3], rc_d[3], sig_d[3]); end
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_fold_stall();
      test_msb_feedback();
      test_records();
      test_random();
      test_reset_abort();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
